// File: rtl/cm3_matrix_pkg.sv
// Shared encodings and field widths for the cm3 bus matrix.
package cm3_matrix_pkg;

  localparam int SIZE_W  = 3;
  localparam int BURST_W = 3;
  localparam int PROT_W  = 4;

  typedef enum logic [1:0] {
    TRANS_IDLE   = 2'b00,
    TRANS_BUSY   = 2'b01,
    TRANS_NONSEQ = 2'b10,
    TRANS_SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [1:0] {
    RESP_OKAY  = 2'b00,
    RESP_ERROR = 2'b01
  } hresp_t;

  typedef enum logic {
    ST_PASS = 1'b0,
    ST_HOLD = 1'b1
  } stage_state_t;

  // NONSEQ and SEQ are the only transfer types that carry an address phase.
  function automatic logic is_active_trans(input logic [1:0] trans);
    return trans[1];
  endfunction

endpackage

// File: rtl/cm3_matrix_input_stage_if.sv
// AHB slave-port signals between one bus master and its matrix input stage.
interface cm3_matrix_input_stage_if #(
  parameter int AW = 32,
  parameter int MW = 4
);
  import cm3_matrix_pkg::*;

  logic                 HSELS;
  logic [AW-1:0]        HADDRS;
  logic [1:0]           HTRANSS;
  logic                 HWRITES;
  logic [SIZE_W-1:0]    HSIZES;
  logic [BURST_W-1:0]   HBURSTS;
  logic [PROT_W-1:0]    HPROTS;
  logic [MW-1:0]        HMASTERS;
  logic                 HMASTLOCKS;
  logic                 HREADYS;
  logic                 HREADYOUTS;
  logic [1:0]           HRESPS;

  modport master (
    output HSELS, HADDRS, HTRANSS, HWRITES, HSIZES, HBURSTS, HPROTS,
           HMASTERS, HMASTLOCKS, HREADYS,
    input  HREADYOUTS, HRESPS
  );

  modport slave (
    input  HSELS, HADDRS, HTRANSS, HWRITES, HSIZES, HBURSTS, HPROTS,
           HMASTERS, HMASTLOCKS, HREADYS,
    output HREADYOUTS, HRESPS
  );

endinterface

// File: rtl/cm3_matrix_input_stage.sv
// Matrix input stage: holds an ungranted address phase and stalls the master
// until the decoder's output stage accepts it.
module cm3_matrix_input_stage
  import cm3_matrix_pkg::*;
#(
  parameter int AW = 32,
  parameter int MW = 4
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  cm3_matrix_input_stage_if.slave bus,
  input  logic                 active_ip,
  input  logic                 readyout_ip,
  input  logic [1:0]           resp_ip,
  output logic                 sel_op,
  output logic [AW-1:0]        addr_op,
  output logic [1:0]           trans_op,
  output logic                 write_op,
  output logic [SIZE_W-1:0]    size_op,
  output logic [BURST_W-1:0]   burst_op,
  output logic [PROT_W-1:0]    prot_op,
  output logic [MW-1:0]        master_op,
  output logic                 mastlock_op,
  output logic                 held_tran_op
);

  logic trans_valid;
  logic accept;
  logic pend;

  stage_state_t state, state_next;

  logic [AW-1:0]      reg_addr;
  logic [1:0]         reg_trans;
  logic               reg_write;
  logic [SIZE_W-1:0]  reg_size;
  logic [BURST_W-1:0] reg_burst;
  logic [PROT_W-1:0]  reg_prot;
  logic [MW-1:0]      reg_master;
  logic               reg_mastlock;

  assign trans_valid = bus.HSELS & is_active_trans(bus.HTRANSS) & bus.HREADYS;
  assign accept      = active_ip & readyout_ip;
  assign pend        = (state == ST_HOLD);

  // Captured on every issued transfer so the copy is ready if the grant is refused.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      reg_addr     <= '0;
      reg_trans    <= TRANS_IDLE;
      reg_write    <= 1'b0;
      reg_size     <= '0;
      reg_burst    <= '0;
      reg_prot     <= '0;
      reg_master   <= '0;
      reg_mastlock <= 1'b0;
    end else if (trans_valid) begin
      reg_addr     <= bus.HADDRS;
      reg_trans    <= bus.HTRANSS;
      reg_write    <= bus.HWRITES;
      reg_size     <= bus.HSIZES;
      reg_burst    <= bus.HBURSTS;
      reg_prot     <= bus.HPROTS;
      reg_master   <= bus.HMASTERS;
      reg_mastlock <= bus.HMASTLOCKS;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state <= ST_PASS;
    end else begin
      state <= state_next;
    end
  end

  // A fresh issue outranks a pending accept; the master cannot issue while
  // stalled, so both only coincide if the master misbehaves.
  always_comb begin
    state_next = state;
    if (trans_valid && !active_ip) begin
      state_next = ST_HOLD;
    end else if (state == ST_HOLD && accept) begin
      state_next = ST_PASS;
    end
  end

  always_comb begin
    sel_op       = bus.HSELS;
    addr_op      = bus.HADDRS;
    trans_op     = bus.HTRANSS;
    write_op     = bus.HWRITES;
    size_op      = bus.HSIZES;
    burst_op     = bus.HBURSTS;
    prot_op      = bus.HPROTS;
    master_op    = bus.HMASTERS;
    mastlock_op  = bus.HMASTLOCKS;
    if (pend) begin
      sel_op      = 1'b1;
      addr_op     = reg_addr;
      trans_op    = reg_trans;
      write_op    = reg_write;
      size_op     = reg_size;
      burst_op    = reg_burst;
      prot_op     = reg_prot;
      master_op   = reg_master;
      mastlock_op = reg_mastlock;
    end
  end

  assign held_tran_op   = pend;
  assign bus.HREADYOUTS = pend ? 1'b0 : readyout_ip;
  assign bus.HRESPS     = pend ? RESP_OKAY : resp_ip;

endmodule

// File: tb/tb_cm3_matrix_input_stage.sv
// Randomised scoreboard bench for cm3_matrix_input_stage against a queue-based model.
module tb_cm3_matrix_input_stage;

  typedef struct packed {
    logic        rst_n;
    logic        hsel;
    logic [31:0] addr;
    logic [1:0]  trans;
    logic        write;
    logic [2:0]  size;
    logic [2:0]  burst;
    logic [3:0]  prot;
    logic [3:0]  master;
    logic        mastlock;
    logic        hready;
    logic        active;
    logic        readyout;
    logic [1:0]  resp;
  } stim_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  trans;
    logic        write;
    logic [2:0]  size;
    logic [2:0]  burst;
    logic [3:0]  prot;
    logic [3:0]  master;
    logic        mastlock;
  } tran_t;

  typedef struct packed {
    logic        sel;
    tran_t       tr;
    logic        held;
    logic        ready;
    logic [1:0]  resp;
  } exp_t;

  logic HCLK = 1'b0;
  logic HRESETn;
  logic active_ip, readyout_ip;
  logic [1:0] resp_ip;
  logic sel_op, write_op, mastlock_op, held_tran_op;
  logic [31:0] addr_op;
  logic [1:0] trans_op;
  logic [2:0] size_op, burst_op;
  logic [3:0] prot_op, master_op;

  int n_cmp = 0;
  int n_bad = 0;
  exp_t exp_q[$];

  // Model: the transfer waiting for a grant, if any.
  tran_t held_q[$];
  tran_t last_issued;

  cm3_matrix_input_stage_if #(.AW(32), .MW(4)) bus ();

  cm3_matrix_input_stage #(.AW(32), .MW(4)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .bus(bus),
    .active_ip(active_ip), .readyout_ip(readyout_ip), .resp_ip(resp_ip),
    .sel_op(sel_op), .addr_op(addr_op), .trans_op(trans_op), .write_op(write_op),
    .size_op(size_op), .burst_op(burst_op), .prot_op(prot_op), .master_op(master_op),
    .mastlock_op(mastlock_op), .held_tran_op(held_tran_op)
  );

  always #5 HCLK = ~HCLK;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic tran_t live_of(input stim_t s);
    tran_t t;
    t.addr = s.addr; t.trans = s.trans; t.write = s.write; t.size = s.size;
    t.burst = s.burst; t.prot = s.prot; t.master = s.master; t.mastlock = s.mastlock;
    return t;
  endfunction

  function automatic exp_t expect_of(input stim_t s);
    exp_t e;
    if (s.rst_n && held_q.size() != 0) begin
      e.sel = 1'b1; e.tr = last_issued; e.held = 1'b1; e.ready = 1'b0; e.resp = 2'b00;
    end else begin
      e.sel = s.hsel; e.tr = live_of(s); e.held = 1'b0; e.ready = s.readyout; e.resp = s.resp;
    end
    return e;
  endfunction

  task automatic cycle(input stim_t s);
    logic issued;
    @(negedge HCLK);
    HRESETn = s.rst_n;
    bus.HSELS = s.hsel; bus.HADDRS = s.addr; bus.HTRANSS = s.trans; bus.HWRITES = s.write;
    bus.HSIZES = s.size; bus.HBURSTS = s.burst; bus.HPROTS = s.prot;
    bus.HMASTERS = s.master; bus.HMASTLOCKS = s.mastlock; bus.HREADYS = s.hready;
    active_ip = s.active; readyout_ip = s.readyout; resp_ip = s.resp;
    #2;
    exp_q.push_back(expect_of(s));
    $display("txn t=%0t rst_n=%0b sel=%0b trans=%0d addr=%h act=%0b rdy=%0b held=%0d",
             $time, s.rst_n, s.hsel, s.trans, s.addr, s.active, s.readyout, held_q.size());
    // Advance the model across the coming rising edge.
    if (!s.rst_n) begin
      held_q.delete();
      last_issued = '0;
    end else begin
      issued = s.hsel && s.trans inside {2'b10, 2'b11} && s.hready;
      if (issued) last_issued = live_of(s);
      if (issued && !s.active) begin
        held_q.delete();
        held_q.push_back(live_of(s));
      end else if (held_q.size() != 0 && s.active && s.readyout) begin
        void'(held_q.pop_front());
      end
    end
  endtask

  // Monitor: compares what the DUT presents just before each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge HCLK);
      #4;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("sel_op", 64'(sel_op), 64'(e.sel));
        check("addr_op", 64'(addr_op), 64'(e.tr.addr));
        check("trans_op", 64'(trans_op), 64'(e.tr.trans));
        check("ctrl_op", 64'({write_op, size_op, burst_op, prot_op, master_op, mastlock_op}),
              64'({e.tr.write, e.tr.size, e.tr.burst, e.tr.prot, e.tr.master, e.tr.mastlock}));
        check("held_tran_op", 64'(held_tran_op), 64'(e.held));
        check("HREADYOUTS", 64'(bus.HREADYOUTS), 64'(e.ready));
        check("HRESPS", 64'(bus.HRESPS), 64'(e.resp));
      end
    end
  end

  initial begin
    stim_t s, z;
    z = '0;
    z.rst_n = 1'b1; z.hready = 1'b1; z.readyout = 1'b1;
    held_q.delete();
    last_issued = '0;

    // Reset state with live inputs at zero.
    s = z; s.rst_n = 1'b0;
    cycle(s); cycle(s);

    // Granted pass-through.
    s = z; s.hsel = 1; s.trans = 2'b10; s.addr = 32'h0001_0004; s.active = 1;
    cycle(s);

    // Held NONSEQ write: three refused cycles, then accept.
    s = z; s.hsel = 1; s.trans = 2'b10; s.write = 1; s.addr = 32'h4000_0010;
    s.size = 3'd2; s.prot = 4'h3; s.master = 4'h5; s.active = 0;
    cycle(s);
    for (int i = 0; i < 3; i++) begin
      s = z; s.hsel = 1; s.trans = 2'b10; s.addr = $urandom; s.hready = 0; s.active = 0;
      cycle(s);
    end
    s = z; s.hready = 0; s.active = 1; s.readyout = 1; s.addr = $urandom;
    cycle(s);
    s = z; s.readyout = 0; s.resp = 2'b00;
    cycle(s);
    s = z;
    cycle(s);

    // Held, accepted, then slave inserts two wait states.
    s = z; s.hsel = 1; s.trans = 2'b10; s.addr = 32'h2000_0100; s.mastlock = 1; s.active = 0;
    cycle(s);
    s = z; s.hready = 0; s.active = 0;
    cycle(s);
    s = z; s.hready = 0; s.active = 1;
    cycle(s);
    for (int i = 0; i < 2; i++) begin
      s = z; s.hready = 0; s.readyout = 0; s.resp = 2'b00;
      cycle(s);
    end
    s = z;
    cycle(s);

    // IDLE with port selected is never held.
    s = z; s.hsel = 1; s.trans = 2'b00; s.addr = 32'h1234_5678; s.active = 0;
    cycle(s); cycle(s);

    // Error response passes through unchanged.
    s = z; s.readyout = 0; s.resp = 2'b01; s.hready = 0;
    cycle(s);
    s.readyout = 1;
    cycle(s);

    // Reset asserted while a transfer is held.
    s = z; s.hsel = 1; s.trans = 2'b11; s.addr = 32'h8000_0040; s.active = 0;
    cycle(s);
    s = z; s.hready = 0; s.active = 0;
    cycle(s);
    s = z; s.rst_n = 0; s.hsel = 1; s.trans = 2'b10; s.addr = 32'h0000_0C00; s.readyout = 1;
    cycle(s);
    s.rst_n = 1; s.active = 1;
    cycle(s);

    // Randomised traffic with a master that mostly respects HREADY.
    for (int n = 0; n < 1500; n++) begin
      s.rst_n    = ($urandom_range(0, 199) != 0);
      s.hsel     = ($urandom_range(0, 3) != 0);
      s.addr     = $urandom;
      s.trans    = 2'($urandom);
      s.write    = 1'($urandom);
      s.size     = 3'($urandom);
      s.burst    = 3'($urandom);
      s.prot     = 4'($urandom);
      s.master   = 4'($urandom);
      s.mastlock = 1'($urandom);
      s.active   = ($urandom_range(0, 2) != 0);
      s.readyout = ($urandom_range(0, 3) != 0);
      s.resp     = ($urandom_range(0, 7) == 0) ? 2'b01 : 2'b00;
      if ($urandom_range(0, 7) == 0) s.hready = 1'($urandom);
      else s.hready = (held_q.size() != 0) ? 1'b0 : s.readyout;
      cycle(s);
    end

    repeat (3) @(negedge HCLK);
    #6;
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expected responses never compared, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
